// File: rtl/noun_loader.sv
// Streams host words into memory_unit one at a time, then launches mem_traversal and waits for it.
// Latency: accepted word reaches REQ next cycle; mem_execute rises the cycle after mem_ready is seen high.
// Backpressure: s_ready only in ACCEPT, one write in flight; mem_ready stalls requests; host stalls are free.
module noun_loader #(
    parameter int         ADDR_W     = 16,
    parameter int         DATA_W     = 32,
    parameter int         BASE_ADDR  = 1,
    parameter int         START_ADDR = 1,
    parameter logic [1:0] FUNC_WRITE = 2'd1,
    parameter int         MAX_WORDS  = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              s_ready,
    output logic [1:0]        mem_func,
    output logic              mem_execute,
    output logic [ADDR_W-1:0] address1,
    output logic [DATA_W-1:0] write_data,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] start_addr,
    output logic              traversal_execute,
    input  logic              traversal_finished,
    output logic [ADDR_W-1:0] words_loaded,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        IDLE, ACCEPT, REQ, ACK, LAUNCH, RUN, DONE, ERR
    } state_t;

    localparam longint ADDR_SPAN = longint'(BASE_ADDR) + longint'(MAX_WORDS);
    localparam bit     ADDR_SPAN_OK = ADDR_SPAN < (longint'(1) << ADDR_W);

    state_t              state_q;
    logic                s_ready_q, mem_exec_q, acked_q, last_q, trav_q;
    logic                busy_q, done_q, err_q;
    logic [1:0]          mem_func_q;
    logic [ADDR_W-1:0]   addr_q, count_q, addr_d;
    logic [DATA_W-1:0]   wdata_q;

    assign addr_d = ADDR_W'(BASE_ADDR) + count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            s_ready_q  <= 1'b0;
            mem_exec_q <= 1'b0;
            mem_func_q <= 2'd0;
            acked_q    <= 1'b0;
            last_q     <= 1'b0;
            trav_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            count_q    <= '0;
        end else begin
            case (state_q)
                IDLE, DONE, ERR: begin
                    if (load_start) begin
                        state_q   <= ACCEPT;
                        s_ready_q <= 1'b1;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        err_q     <= 1'b0;
                        count_q   <= '0;
                    end
                end
                ACCEPT: begin
                    if (s_valid) begin
                        s_ready_q <= 1'b0;
                        // A word arriving with the counter already at the limit is dropped, not written.
                        if (count_q == ADDR_W'(MAX_WORDS)) begin
                            state_q <= ERR;
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            addr_q  <= addr_d;
                            wdata_q <= s_data;
                            last_q  <= s_last;
                            state_q <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        mem_exec_q <= 1'b1;
                        mem_func_q <= FUNC_WRITE;
                        acked_q    <= 1'b0;
                        state_q    <= ACK;
                    end
                end
                ACK: begin
                    // mem_ready falling is the acceptance; rising again is completion.
                    if (!acked_q) begin
                        if (!mem_ready) begin
                            mem_exec_q <= 1'b0;
                            acked_q    <= 1'b1;
                        end
                    end else if (mem_ready) begin
                        mem_func_q <= 2'd0;
                        count_q    <= count_q + 1'b1;
                        if (last_q) begin
                            trav_q  <= 1'b1;
                            state_q <= LAUNCH;
                        end else begin
                            s_ready_q <= 1'b1;
                            state_q   <= ACCEPT;
                        end
                    end
                end
                LAUNCH: state_q <= RUN;
                RUN: begin
                    if (traversal_finished) begin
                        trav_q  <= 1'b0;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) assert (ADDR_SPAN_OK) else $error("BASE_ADDR + MAX_WORDS wraps the address space");
    end
`endif

    assign s_ready           = s_ready_q;
    assign mem_func          = mem_func_q;
    assign mem_execute       = mem_exec_q;
    assign address1          = addr_q;
    assign write_data        = wdata_q;
    assign start_addr        = ADDR_W'(START_ADDR);
    assign traversal_execute = trav_q;
    assign words_loaded      = count_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign error             = err_q;

endmodule

// File: tb/tb_noun_loader.sv
// Directed bench for noun_loader: u0 uses default limits, u1 has MAX_WORDS=2 for overflow.
// A negedge memory model logs every accepted write and answers with a fixed two-cycle busy window.
module tb_noun_loader;
    localparam int AW = 16;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          load_start [2];
    logic          s_valid [2];
    logic          s_last [2];
    logic [DW-1:0] s_data [2];
    logic          mem_ready [2];
    logic          traversal_finished [2];
    logic          s_ready [2];
    logic          mem_execute [2];
    logic          traversal_execute [2];
    logic          busy [2];
    logic          done [2];
    logic          error [2];
    logic [1:0]    mem_func [2];
    logic [AW-1:0] address1 [2];
    logic [AW-1:0] start_addr [2];
    logic [AW-1:0] words_loaded [2];
    logic [DW-1:0] write_data [2];

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    int            wcnt [2];
    logic [AW-1:0] wa [2][16];
    logic [DW-1:0] wd [2][16];
    logic [1:0]    wf [2][16];
    int            mcnt [2];
    int            hold_exec [2];
    int            rise_cyc [2];
    logic          hold_low [2];
    logic          trav_seen [2];
    logic          busy_prev [2];

    noun_loader #(.ADDR_W(AW), .DATA_W(DW)) u0 (
        .clk(clk), .rst(rst), .load_start(load_start[0]), .s_valid(s_valid[0]),
        .s_data(s_data[0]), .s_last(s_last[0]), .s_ready(s_ready[0]), .mem_func(mem_func[0]),
        .mem_execute(mem_execute[0]), .address1(address1[0]), .write_data(write_data[0]),
        .mem_ready(mem_ready[0]), .start_addr(start_addr[0]), .traversal_execute(traversal_execute[0]),
        .traversal_finished(traversal_finished[0]), .words_loaded(words_loaded[0]),
        .busy(busy[0]), .done(done[0]), .error(error[0]));

    noun_loader #(.ADDR_W(AW), .DATA_W(DW), .MAX_WORDS(2)) u1 (
        .clk(clk), .rst(rst), .load_start(load_start[1]), .s_valid(s_valid[1]),
        .s_data(s_data[1]), .s_last(s_last[1]), .s_ready(s_ready[1]), .mem_func(mem_func[1]),
        .mem_execute(mem_execute[1]), .address1(address1[1]), .write_data(write_data[1]),
        .mem_ready(mem_ready[1]), .start_addr(start_addr[1]), .traversal_execute(traversal_execute[1]),
        .traversal_finished(traversal_finished[1]), .words_loaded(words_loaded[1]),
        .busy(busy[1]), .done(done[1]), .error(error[1]));

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                mem_ready[i] = 1'b1; mcnt[i] = 0; wcnt[i] = 0; hold_exec[i] = 0;
                trav_seen[i] = 1'b0; busy_prev[i] = 1'b0; rise_cyc[i] = 0;
            end else begin
                if (busy[i] && !busy_prev[i]) begin
                    wcnt[i] = 0; hold_exec[i] = 0; trav_seen[i] = 1'b0;
                end
                busy_prev[i] = busy[i];
                if (traversal_execute[i]) trav_seen[i] = 1'b1;
                if (hold_low[i] && mem_execute[i]) hold_exec[i]++;
                if (mcnt[i] > 0) begin
                    mcnt[i]--;
                    if (mcnt[i] == 0) begin
                        mem_ready[i] = !hold_low[i];
                        rise_cyc[i] = cyc;
                    end
                end else if (hold_low[i]) begin
                    mem_ready[i] = 1'b0;
                end else if (mem_execute[i] && mem_ready[i]) begin
                    if (wcnt[i] < 16) begin
                        wa[i][wcnt[i]] = address1[i];
                        wd[i][wcnt[i]] = write_data[i];
                        wf[i][wcnt[i]] = mem_func[i];
                    end
                    wcnt[i]++;
                    mem_ready[i] = 1'b0;
                    mcnt[i] = 2;
                end else begin
                    mem_ready[i] = 1'b1;
                end
            end
        end
    end

    task automatic pulse_start(input int i);
        load_start[i] = 1'b1;
        @(negedge clk);
        load_start[i] = 1'b0;
    endtask

    // Holds s_valid until the loader takes the word, so refused cycles must not lose it.
    task automatic send(input int i, input logic [DW-1:0] d, input logic last, input int gap);
        int n = 0;
        s_valid[i] = 1'b1; s_data[i] = d; s_last[i] = last;
        while (!s_ready[i] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            tests++; fails++;
            $display("FAIL send_timeout: s_ready=%0b after %0d cycles, required 1", s_ready[i], n);
        end
        @(negedge clk);
        s_valid[i] = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_launch(input int i, output int lcyc);
        int n = 0;
        while (!traversal_execute[i] && n < 300) begin
            @(negedge clk);
            n++;
        end
        lcyc = cyc;
        tests++;
        if (traversal_execute[i] !== 1'b1) begin
            fails++;
            $display("FAIL launch_timeout: traversal_execute=%0b, required 1", traversal_execute[i]);
        end
    endtask

    task automatic finish_traversal(input int i);
        @(negedge clk);
        traversal_finished[i] = 1'b1;
        @(negedge clk);
        traversal_finished[i] = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests++; if (s_ready[0] !== 1'b0) begin fails++; $display("FAIL rst_s_ready: got %0b want 0", s_ready[0]); end
        tests++; if (mem_execute[0] !== 1'b0) begin fails++; $display("FAIL rst_mem_execute: got %0b want 0", mem_execute[0]); end
        tests++; if (mem_func[0] !== 2'd0) begin fails++; $display("FAIL rst_mem_func: got %0d want 0", mem_func[0]); end
        tests++; if (address1[0] !== 16'd0) begin fails++; $display("FAIL rst_address1: got %0h want 0", address1[0]); end
        tests++; if (write_data[0] !== 32'd0) begin fails++; $display("FAIL rst_write_data: got %0h want 0", write_data[0]); end
        tests++; if (start_addr[0] !== 16'd1) begin fails++; $display("FAIL rst_start_addr: got %0h want 1", start_addr[0]); end
        tests++; if (traversal_execute[0] !== 1'b0) begin fails++; $display("FAIL rst_trav: got %0b want 0", traversal_execute[0]); end
        tests++; if (words_loaded[0] !== 16'd0) begin fails++; $display("FAIL rst_words: got %0d want 0", words_loaded[0]); end
        tests++; if ({busy[0], done[0], error[0]} !== 3'b000) begin fails++; $display("FAIL rst_status: got %b want 000", {busy[0], done[0], error[0]}); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic;
        int lc;
        logic [DW-1:0] exp_d [3];
        exp_d[0] = 32'hA; exp_d[1] = 32'hB; exp_d[2] = 32'hC;
        pulse_start(0);
        tests++; if (busy[0] !== 1'b1 || s_ready[0] !== 1'b1) begin fails++; $display("FAIL basic_accept: busy=%0b s_ready=%0b want 1 1", busy[0], s_ready[0]); end
        send(0, 32'hA, 1'b0, 0);
        send(0, 32'hB, 1'b0, 0);
        send(0, 32'hC, 1'b1, 0);
        wait_launch(0, lc);
        #1;
        tests++; if (wcnt[0] !== 3) begin fails++; $display("FAIL basic_write_count: got %0d want 3", wcnt[0]); end
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (wa[0][k] !== AW'(k + 1) || wd[0][k] !== exp_d[k] || wf[0][k] !== 2'd1) begin
                fails++;
                $display("FAIL basic_write%0d: got addr %0h data %0h func %0d, want addr %0h data %0h func 1",
                         k, wa[0][k], wd[0][k], wf[0][k], k + 1, exp_d[k]);
            end
        end
        tests++; if (words_loaded[0] !== 16'd3 || busy[0] !== 1'b1) begin fails++; $display("FAIL basic_launch_state: words=%0d busy=%0b want 3 1", words_loaded[0], busy[0]); end
        // finished while still in LAUNCH must be ignored
        traversal_finished[0] = 1'b1;
        @(negedge clk);
        traversal_finished[0] = 1'b0;
        tests++; if (done[0] !== 1'b0 || traversal_execute[0] !== 1'b1) begin fails++; $display("FAIL basic_early_finish: done=%0b trav=%0b want 0 1", done[0], traversal_execute[0]); end
        finish_traversal(0);
        tests++; if ({done[0], busy[0], traversal_execute[0]} !== 3'b100) begin fails++; $display("FAIL basic_done: done/busy/trav=%b want 100", {done[0], busy[0], traversal_execute[0]}); end
        tests++; if (words_loaded[0] !== 16'd3) begin fails++; $display("FAIL basic_words_after: got %0d want 3", words_loaded[0]); end
    endtask

    task automatic test_host_stall;
        int lc;
        pulse_start(0);
        tests++; if (done[0] !== 1'b0 || busy[0] !== 1'b1) begin fails++; $display("FAIL stall_restart: done=%0b busy=%0b want 0 1", done[0], busy[0]); end
        send(0, 32'h11, 1'b0, 5);
        send(0, 32'h22, 1'b0, 5);
        send(0, 32'h33, 1'b1, 0);
        wait_launch(0, lc);
        #1;
        tests++; if (wcnt[0] !== 3) begin fails++; $display("FAIL stall_write_count: got %0d want 3", wcnt[0]); end
        tests++;
        if (wa[0][0] !== 16'd1 || wa[0][1] !== 16'd2 || wa[0][2] !== 16'd3 ||
            wd[0][0] !== 32'h11 || wd[0][1] !== 32'h22 || wd[0][2] !== 32'h33) begin
            fails++;
            $display("FAIL stall_image: got %0h:%0h %0h:%0h %0h:%0h want 1:11 2:22 3:33",
                     wa[0][0], wd[0][0], wa[0][1], wd[0][1], wa[0][2], wd[0][2]);
        end
        finish_traversal(0);
    endtask

    task automatic test_mem_stall;
        int lc;
        hold_low[0] = 1'b1;
        @(negedge clk);
        pulse_start(0);
        send(0, 32'h71, 1'b0, 0);
        repeat (10) @(negedge clk);
        #1;
        tests++; if (mem_execute[0] !== 1'b0 || hold_exec[0] !== 0) begin fails++; $display("FAIL memstall_exec: mem_execute=%0b high_cycles=%0d want 0 0", mem_execute[0], hold_exec[0]); end
        tests++; if (wcnt[0] !== 0) begin fails++; $display("FAIL memstall_early_write: got %0d want 0", wcnt[0]); end
        hold_low[0] = 1'b0;
        send(0, 32'h72, 1'b1, 0);
        wait_launch(0, lc);
        #1;
        tests++;
        if (wcnt[0] !== 2 || wa[0][0] !== 16'd1 || wd[0][0] !== 32'h71 || wa[0][1] !== 16'd2 || wd[0][1] !== 32'h72) begin
            fails++;
            $display("FAIL memstall_writes: count %0d, %0h:%0h %0h:%0h want 2, 1:71 2:72", wcnt[0], wa[0][0], wd[0][0], wa[0][1], wd[0][1]);
        end
        finish_traversal(0);
    endtask

    task automatic test_overflow;
        pulse_start(1);
        send(1, 32'h1, 1'b0, 0);
        send(1, 32'h2, 1'b0, 0);
        send(1, 32'h3, 1'b1, 0);
        repeat (3) @(negedge clk);
        #1;
        tests++; if ({error[1], busy[1], s_ready[1]} !== 3'b100) begin fails++; $display("FAIL ovf_status: error/busy/s_ready=%b want 100", {error[1], busy[1], s_ready[1]}); end
        tests++;
        if (wcnt[1] !== 2 || wa[1][0] !== 16'd1 || wd[1][0] !== 32'h1 || wa[1][1] !== 16'd2 || wd[1][1] !== 32'h2) begin
            fails++;
            $display("FAIL ovf_writes: count %0d, %0h:%0h %0h:%0h want 2, 1:1 2:2", wcnt[1], wa[1][0], wd[1][0], wa[1][1], wd[1][1]);
        end
        tests++; if (trav_seen[1] !== 1'b0) begin fails++; $display("FAIL ovf_trav: traversal_execute seen=%0b want 0", trav_seen[1]); end
        tests++; if (words_loaded[1] !== 16'd2) begin fails++; $display("FAIL ovf_words: got %0d want 2", words_loaded[1]); end
        repeat (4) @(negedge clk);
        tests++; if (error[1] !== 1'b1) begin fails++; $display("FAIL ovf_sticky: error=%0b want 1", error[1]); end
        pulse_start(1);
        tests++; if (error[1] !== 1'b0 || busy[1] !== 1'b1) begin fails++; $display("FAIL ovf_clear: error=%0b busy=%0b want 0 1", error[1], busy[1]); end
    endtask

    task automatic test_rst_mid;
        pulse_start(0);
        send(0, 32'h55, 1'b0, 0);
        @(negedge clk);
        tests++; if (mem_execute[0] !== 1'b1 || mem_func[0] !== 2'd1) begin fails++; $display("FAIL rstmid_req: mem_execute=%0b func=%0d want 1 1", mem_execute[0], mem_func[0]); end
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if (mem_execute[0] !== 1'b0 || busy[0] !== 1'b0 || words_loaded[0] !== 16'd0 || mem_func[0] !== 2'd0) begin
            fails++;
            $display("FAIL rstmid_state: exec=%0b busy=%0b words=%0d func=%0d want 0 0 0 0", mem_execute[0], busy[0], words_loaded[0], mem_func[0]);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single;
        int lc;
        pulse_start(0);
        tests++; if (busy[0] !== 1'b1) begin fails++; $display("FAIL single_restart: busy=%0b want 1", busy[0]); end
        send(0, 32'hAB, 1'b1, 0);
        wait_launch(0, lc);
        #1;
        tests++; if (wcnt[0] !== 1 || wa[0][0] !== 16'd1 || wd[0][0] !== 32'hAB) begin fails++; $display("FAIL single_write: count %0d %0h:%0h want 1 1:ab", wcnt[0], wa[0][0], wd[0][0]); end
        tests++; if (lc !== rise_cyc[0] + 1) begin fails++; $display("FAIL single_launch_cycle: launch at %0d want %0d", lc, rise_cyc[0] + 1); end
        tests++; if (words_loaded[0] !== 16'd1) begin fails++; $display("FAIL single_words: got %0d want 1", words_loaded[0]); end
        @(negedge clk);
        finish_traversal(0);
        tests++; if (done[0] !== 1'b1 || traversal_execute[0] !== 1'b0) begin fails++; $display("FAIL single_done: done=%0b trav=%0b want 1 0", done[0], traversal_execute[0]); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            load_start[i] = 1'b0; s_valid[i] = 1'b0; s_last[i] = 1'b0; s_data[i] = '0;
            traversal_finished[i] = 1'b0; hold_low[i] = 1'b0;
        end
        @(negedge clk);
        test_reset();
        test_basic();
        test_host_stall();
        test_mem_stall();
        test_overflow();
        test_rst_mid();
        test_single();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
